ex_stage_muldiv: RTL and testbench

//  Parametrised execute stage for the 5-stage MIPS-style pipeline. It contains:
//  - 3-way operand forwarding for A and B.
//  - Immediate select and destination-register select.
//  - A single-cycle ALU.
//  - An iterative unsigned multiply/divide unit with HI/LO registers.
//  - The registered EX/MEM pipeline boundary.
//  The stage sits between ID/EX and MEM. It stalls upstream when mult/div results are not ready.

---
 rtl/ex_stage_muldiv.sv | 220 ++++++++++++++++++++++
 tb/tb_ex_stage_muldiv.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_muldiv.sv
// ex_stage_muldiv: execute stage with operand forwarding, single-cycle ALU,
// iterative unsigned multiply/divide with HI/LO, and the EX/MEM register.
//==============================================================================
// Module   : ex_stage_muldiv
// Brief    : MIPS-style EX stage, ALU + iterative MULTU/DIVU + EX/MEM register
// Revision : 1.0
//==============================================================================
`default_nettype none

module ex_stage_muldiv #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SH_W   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] mem_fwd,
  input  logic [DATA_W-1:0] wb_fwd,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [REG_W-1:0]  rt,
  input  logic [REG_W-1:0]  rd,
  input  logic              reg_dst,
  input  logic              reg_write,
  input  logic              mem_stall,
  output logic              stall_out,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_dest,
  output logic              out_reg_write,
  output logic              md_busy
);

  localparam logic [3:0] c_OP_ADD   = 4'd0;
  localparam logic [3:0] c_OP_SUB   = 4'd1;
  localparam logic [3:0] c_OP_AND   = 4'd2;
  localparam logic [3:0] c_OP_OR    = 4'd3;
  localparam logic [3:0] c_OP_XOR   = 4'd4;
  localparam logic [3:0] c_OP_NOR   = 4'd5;
  localparam logic [3:0] c_OP_SLT   = 4'd6;
  localparam logic [3:0] c_OP_SLTU  = 4'd7;
  localparam logic [3:0] c_OP_SLL   = 4'd8;
  localparam logic [3:0] c_OP_SRL   = 4'd9;
  localparam logic [3:0] c_OP_SRA   = 4'd10;
  localparam logic [3:0] c_OP_LUI   = 4'd11;
  localparam logic [3:0] c_OP_MULTU = 4'd12;
  localparam logic [3:0] c_OP_DIVU  = 4'd13;
  localparam logic [3:0] c_OP_MFHI  = 4'd14;
  localparam logic [3:0] c_OP_MFLO  = 4'd15;

  localparam logic [0:0] c_ST_IDLE = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b_fwd;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_alu;
  logic [SH_W-1:0]   w_sh;
  logic              w_accept;
  logic              w_md_op;
  logic              w_md_start_op;
  logic              w_md_start;
  logic              w_last;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [SH_W-1:0]   r_cnt;
  logic [DATA_W-1:0] r_acc_hi;
  logic [DATA_W-1:0] r_acc_lo;
  logic [DATA_W-1:0] r_op_b;
  logic              r_is_div;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_shr;
  logic [DATA_W:0]   w_trial;
  logic [DATA_W-1:0] w_acc_hi_nxt;
  logic [DATA_W-1:0] w_acc_lo_nxt;

  always_comb begin
    case (fwd_a_sel)
      2'b01:   w_a = mem_fwd;
      2'b10:   w_a = wb_fwd;
      default: w_a = rs_data;
    endcase
    case (fwd_b_sel)
      2'b01:   w_b_fwd = mem_fwd;
      2'b10:   w_b_fwd = wb_fwd;
      default: w_b_fwd = rt_data;
    endcase
  end

  assign w_b  = use_imm ? imm : w_b_fwd;
  assign w_sh = w_a[SH_W-1:0];

  always_comb begin
    w_alu = '0;
    case (alu_op)
      c_OP_ADD:  w_alu = w_a + w_b;
      c_OP_SUB:  w_alu = w_a - w_b;
      c_OP_AND:  w_alu = w_a & w_b;
      c_OP_OR:   w_alu = w_a | w_b;
      c_OP_XOR:  w_alu = w_a ^ w_b;
      c_OP_NOR:  w_alu = ~(w_a | w_b);
      c_OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      c_OP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
      c_OP_SLL:  w_alu = w_b << w_sh;
      c_OP_SRL:  w_alu = w_b >> w_sh;
      c_OP_SRA:  w_alu = $signed(w_b) >>> w_sh;
      c_OP_LUI:  w_alu = w_b << (DATA_W/2);
      c_OP_MFHI: w_alu = r_hi;
      c_OP_MFLO: w_alu = r_lo;
      default:   w_alu = '0;
    endcase
  end

  // Only HI/LO-touching ops wait on the unit; everything else flows past it.
  assign w_md_op       = (alu_op[3:2] == 2'b11);
  assign w_md_start_op = (alu_op == c_OP_MULTU) || (alu_op == c_OP_DIVU);
  assign stall_out     = mem_stall | (md_busy & in_valid & w_md_op);
  assign w_accept      = in_valid & ~stall_out;
  assign w_md_start    = w_accept & w_md_start_op;
  assign w_last        = (r_cnt == SH_W'(DATA_W-1));

  always_ff @(posedge clock) begin
    if (reset) r_state <= c_ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: if (w_md_start) w_state_nxt = c_ST_RUN;
      c_ST_RUN:  if (w_last)     w_state_nxt = c_ST_IDLE;
      default:   w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    md_busy = (r_state == c_ST_RUN);
  end

  // Multiply: shift {hi,lo} right after conditionally adding B into hi.
  // Divide: shift {rem,quot} left, keep the trial subtraction if non-negative.
  always_comb begin
    w_sum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_op_b} : '0);
    w_shr   = {r_acc_hi, r_acc_lo[DATA_W-1]};
    w_trial = w_shr - {1'b0, r_op_b};
    if (r_is_div) begin
      if (!w_trial[DATA_W]) begin
        w_acc_hi_nxt = w_trial[DATA_W-1:0];
        w_acc_lo_nxt = {r_acc_lo[DATA_W-2:0], 1'b1};
      end else begin
        w_acc_hi_nxt = w_shr[DATA_W-1:0];
        w_acc_lo_nxt = {r_acc_lo[DATA_W-2:0], 1'b0};
      end
    end else begin
      w_acc_hi_nxt = w_sum[DATA_W:1];
      w_acc_lo_nxt = {w_sum[0], r_acc_lo[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_op_b   <= '0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (w_md_start) begin
      r_cnt    <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= w_a;
      r_op_b   <= w_b;
      r_is_div <= (alu_op == c_OP_DIVU);
    end else if (md_busy) begin
      r_cnt    <= r_cnt + 1'b1;
      r_acc_hi <= w_acc_hi_nxt;
      r_acc_lo <= w_acc_lo_nxt;
      if (w_last) begin
        r_hi <= w_acc_hi_nxt;
        r_lo <= w_acc_lo_nxt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_dest       <= '0;
      out_reg_write  <= 1'b0;
    end else if (!mem_stall) begin
      if (w_accept) begin
        out_valid      <= 1'b1;
        out_result     <= w_alu;
        out_store_data <= w_b_fwd;
        out_dest       <= reg_dst ? rd : rt;
        out_reg_write  <= reg_write & ~w_md_start_op;
      end else begin
        out_valid     <= 1'b0;
        out_reg_write <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_stage_muldiv.sv
// tb_ex_stage_muldiv: randomized + directed scoreboard bench for ex_stage_muldiv.
//==============================================================================
// Module   : tb_ex_stage_muldiv
// Brief    : Scoreboard bench with a behavioural EX-stage reference model
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_ex_stage_muldiv;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int SH_W   = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [3:0]        alu_op = '0;
  logic [DATA_W-1:0] rs_data = '0, rt_data = '0, mem_fwd = '0, wb_fwd = '0, imm = '0;
  logic [1:0]        fwd_a_sel = '0, fwd_b_sel = '0;
  logic              use_imm = 1'b0, reg_dst = 1'b0, reg_write = 1'b0, mem_stall = 1'b0;
  logic [REG_W-1:0]  rt = '0, rd = '0;
  logic              stall_out, out_valid, out_reg_write, md_busy;
  logic [DATA_W-1:0] out_result, out_store_data;
  logic [REG_W-1:0]  out_dest;

  ex_stage_muldiv #(.DATA_W(DATA_W), .REG_W(REG_W), .SH_W(SH_W)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .alu_op(alu_op),
    .rs_data(rs_data), .rt_data(rt_data), .mem_fwd(mem_fwd), .wb_fwd(wb_fwd),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .imm(imm), .use_imm(use_imm),
    .rt(rt), .rd(rd), .reg_dst(reg_dst), .reg_write(reg_write), .mem_stall(mem_stall),
    .stall_out(stall_out), .out_valid(out_valid), .out_result(out_result),
    .out_store_data(out_store_data), .out_dest(out_dest),
    .out_reg_write(out_reg_write), .md_busy(md_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rtd, memf, wbf, imm;
    logic [1:0]  sa, sb;
    logic        ui;
    logic [4:0]  rt, rd;
    logic        rdst, rw;
  } instr_t;

  // kind: 0 reset, 1 hold (mem_stall), 2 load, 3 bubble
  typedef struct {
    int          kind;
    logic        valid;
    logic [31:0] res, st;
    logic [4:0]  dest;
    logic        rw;
    bit          res_x;
  } exp_t;

  exp_t        sbq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          rand_stall = 0;

  // Reference state: HI/LO and the remaining busy cycles of the unit.
  int          busy_cnt = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] r,
                                      input logic [31:0] mf, input logic [31:0] wf);
    if (sel == 2'b01) return mf;
    if (sel == 2'b10) return wf;
    return r;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    int sh;
    sa = a; sbv = b; sh = int'(a % 32);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return (sa < sbv) ? 32'd1 : 32'd0;
      4'd7:  return (a < b) ? 32'd1 : 32'd0;
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: return sbv >>> sh;
      4'd11: return b * 32'd65536;
      4'd14: return m_hi;
      4'd15: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic apply(input instr_t ins, input bit v, input bit ms, input bit rst,
                       output bit acc);
    logic [31:0] a, bf, b;
    logic [63:0] prod;
    bit exp_stall, mdstart;
    exp_t e;
    @(negedge clock);
    reset = rst; in_valid = v; mem_stall = ms; alu_op = ins.op;
    rs_data = ins.rs; rt_data = ins.rtd; mem_fwd = ins.memf; wb_fwd = ins.wbf; imm = ins.imm;
    fwd_a_sel = ins.sa; fwd_b_sel = ins.sb; use_imm = ins.ui;
    rt = ins.rt; rd = ins.rd; reg_dst = ins.rdst; reg_write = ins.rw;
    #1;
    a  = fwd(ins.sa, ins.rs, ins.memf, ins.wbf);
    bf = fwd(ins.sb, ins.rtd, ins.memf, ins.wbf);
    b  = ins.ui ? ins.imm : bf;
    exp_stall = ms || (busy_cnt > 0 && v && ins.op >= 4'd12);
    mdstart   = (ins.op == 4'd12) || (ins.op == 4'd13);
    chk("md_busy", {31'b0, md_busy}, {31'b0, busy_cnt > 0});
    if (!rst) chk("stall_out", {31'b0, stall_out}, {31'b0, exp_stall});
    acc = v && !exp_stall && !rst;
    e = '{kind: 3, valid: 0, res: '0, st: '0, dest: '0, rw: 0, res_x: 0};
    if (rst) e.kind = 0;
    else if (ms) e.kind = 1;
    else if (acc) begin
      e.kind = 2; e.valid = 1;
      e.res_x = mdstart;
      e.res = mdstart ? 32'd0 : alu_ref(ins.op, a, b);
      e.st = bf;
      e.dest = ins.rdst ? ins.rd : ins.rt;
      e.rw = ins.rw && !mdstart;
    end
    sbq.push_back(e);
    if (rst) begin
      busy_cnt = 0; m_hi = '0; m_lo = '0;
    end else begin
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin m_hi = p_hi; m_lo = p_lo; end
      end
      if (acc && mdstart) begin
        busy_cnt = DATA_W;
        if (ins.op == 4'd12) begin
          prod = 64'(a) * 64'(b);
          p_hi = prod[63:32]; p_lo = prod[31:0];
        end else if (b == 0) begin
          p_lo = 32'hFFFF_FFFF; p_hi = a;
        end else begin
          p_lo = a / b; p_hi = a % b;
        end
      end
    end
  endtask

  task automatic issue(input instr_t ins, input int force_ms, output int stalls);
    bit acc, ms;
    int n, fm;
    n = 0; stalls = 0; fm = force_ms;
    do begin
      ms = (fm > 0) ? 1'b1 : (rand_stall && $urandom_range(0, 9) == 0);
      if (fm > 0) fm--;
      apply(ins, 1'b1, ms, 1'b0, acc);
      if (!acc) stalls++;
      n++;
    end while (!acc && n < 200);
    if (!acc) chk("issue_timeout", 32'd0, 32'd1);
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    instr_t i;
    i = '{op: op, rs: a, rtd: b, memf: $urandom, wbf: $urandom, imm: $urandom,
          sa: 2'b00, sb: 2'b00, ui: 1'b0, rt: 5'd2, rd: 5'd3, rdst: 1'b1, rw: 1'b1};
    return i;
  endfunction

  function automatic instr_t rnd();
    instr_t i;
    i = '{op: 4'($urandom_range(0, 15)), rs: $urandom, rtd: $urandom, memf: $urandom,
          wbf: $urandom, imm: $urandom, sa: 2'($urandom_range(0, 3)),
          sb: 2'($urandom_range(0, 3)), ui: 1'($urandom_range(0, 1)),
          rt: 5'($urandom), rd: 5'($urandom), rdst: 1'($urandom_range(0, 1)),
          rw: 1'($urandom_range(0, 1))};
    if (i.op == 4'd13 && $urandom_range(0, 5) == 0) begin
      i.rtd = '0; i.memf = '0; i.wbf = '0; i.imm = '0;
    end else if (i.op == 4'd13 && $urandom_range(0, 2) == 0) begin
      i.rtd = $urandom_range(1, 300); i.imm = $urandom_range(1, 300);
      i.memf = $urandom_range(1, 300); i.wbf = $urandom_range(1, 300);
    end
    return i;
  endfunction

  task automatic idle(input int n);
    bit acc;
    for (int k = 0; k < n; k++) apply(rnd(), 1'b0, 1'b0, 1'b0, acc);
  endtask

  // Monitor: one scoreboard entry per clock edge, compared after the edge.
  initial begin
    exp_t e, last, x;
    last = '{kind: 0, valid: 0, res: '0, st: '0, dest: '0, rw: 0, res_x: 0};
    forever begin
      @(posedge clock);
      #1;
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        case (e.kind)
          0: x = '{kind: 0, valid: 0, res: '0, st: '0, dest: '0, rw: 0, res_x: 0};
          1: x = last;
          2: x = e;
          default: begin x = last; x.valid = 0; x.rw = 0; end
        endcase
        chk("out_valid", {31'b0, out_valid}, {31'b0, x.valid});
        if (!x.res_x) chk("out_result", out_result, x.res);
        chk("out_store_data", out_store_data, x.st);
        chk("out_dest", {27'b0, out_dest}, {27'b0, x.dest});
        chk("out_reg_write", {31'b0, out_reg_write}, {31'b0, x.rw});
        last = x;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    instr_t i;
    bit acc;
    int st;
    apply(mk(4'd0, 0, 0), 1'b0, 1'b0, 1'b1, acc);
    apply(mk(4'd0, 0, 0), 1'b0, 1'b0, 1'b1, acc);
    idle(1);

    // Forwarded ADD: A from MEM (10) + rt (3) = 13
    i = mk(4'd0, 5, 3); i.sa = 2'b01; i.memf = 10;
    issue(i, 0, st);
    issue(mk(4'd1, 0, 1), 0, st);
    issue(mk(4'd6, 32'hFFFF_FFFF, 1), 0, st);
    issue(mk(4'd7, 32'hFFFF_FFFF, 1), 0, st);
    i = mk(4'd0, 1, 2); i.sa = 2'b11; i.sb = 2'b11;
    issue(i, 0, st);

    // MULTU then MFLO immediately: 32 stall cycles
    issue(mk(4'd12, 7, 6), 0, st);
    issue(mk(4'd15, 0, 0), 0, st);
    chk("mflo_stall_cycles", st, 32);
    issue(mk(4'd14, 0, 0), 0, st);
    chk("mfhi_no_stall", st, 0);

    // ADD behind MULTU flows without stall
    issue(mk(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 0, st);
    issue(mk(4'd0, 100, 23), 0, st);
    chk("add_behind_multu_stall", st, 0);
    issue(mk(4'd14, 0, 0), 0, st);
    issue(mk(4'd15, 0, 0), 0, st);

    issue(mk(4'd13, 100, 7), 0, st);
    issue(mk(4'd15, 0, 0), 0, st);
    issue(mk(4'd14, 0, 0), 0, st);
    issue(mk(4'd13, 9, 0), 0, st);
    idle(DATA_W + 2);
    issue(mk(4'd15, 0, 0), 0, st);
    issue(mk(4'd14, 0, 0), 0, st);

    // mem_stall for 3 cycles with a valid instruction waiting
    issue(mk(4'd4, 32'h1234_5678, 32'h0F0F_0F0F), 3, st);
    chk("mem_stall_cycles", st, 3);

    // Reset ten cycles into a MULTU aborts it
    issue(mk(4'd12, 32'hDEAD_BEEF, 32'h1000_0001), 0, st);
    idle(9);
    apply(mk(4'd0, 0, 0), 1'b0, 1'b0, 1'b1, acc);
    issue(mk(4'd14, 0, 0), 0, st);
    issue(mk(4'd15, 0, 0), 0, st);

    rand_stall = 1;
    for (int n = 0; n < 400; n++) begin
      idle($urandom_range(0, 2));
      issue(rnd(), 0, st);
    end
    rand_stall = 0;
    idle(2);
    @(posedge clock);
    #3;
    chk("scoreboard_drained", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
